// File: rtl/demux2_reg32.sv
// ---------------------------------------------------------------------------
// demux2_reg32 -- registered 1-to-2 demultiplexer with request/ack handshake
//
// A single WIDTH-bit source bus is captured into one of two holding
// registers. The destination is chosen when the request (Load) is accepted.
// The capture itself happens on the edge where the source signals valid
// data (Ack). Typical use: steering memory read data into the instruction
// register (Out0) or the memory data register (Out1).
//
// Parameters
//   WIDTH          data width of In / Out0 / Out1
//   TIMEOUT_CYCLES maximum WAIT edges before a capture is abandoned
//                  (1 .. 2**CNT_W)
//   CNT_W          wait counter width
//
// Build option
//   DEMUX_TIMEOUT_EN  defined   : wait counter and Timeout pulse present
//                     undefined : WAIT persists until Ack or Reset,
//                                 Timeout tied low, TIMEOUT_CYCLES/CNT_W unused
//
// Ports
//   Clk      in   rising-edge clock
//   Reset    in   synchronous, active-high reset
//   In       in   source data, sampled only on the capturing edge
//   Sel      in   destination select (0 -> Out0, 1 -> Out1), sampled with Load
//   Load     in   capture request, honoured only in IDLE
//   Ack      in   source data valid, honoured only in WAIT
//   Out0     out  holding register 0
//   Out1     out  holding register 1
//   Busy     out  high while a capture is pending (WAIT)
//   Done0    out  one-cycle pulse after a capture into Out0
//   Done1    out  one-cycle pulse after a capture into Out1
//   Timeout  out  one-cycle pulse when a capture is abandoned
//
// Every output comes straight from a flop; no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module demux2_reg32 #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_W          = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] In,
  input  logic             Sel,
  input  logic             Load,
  input  logic             Ack,
  output logic [WIDTH-1:0] Out0,
  output logic [WIDTH-1:0] Out1,
  output logic             Busy,
  output logic             Done0,
  output logic             Done1,
  output logic             Timeout
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic [WIDTH-1:0] out0_q, out0_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;

`ifdef DEMUX_TIMEOUT_EN
  // Counter value seen on the last permitted WAIT edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`else
  // Timeout machinery is compiled out; the parameters stay in the interface.
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES == CNT_W);
`endif

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    sel_d   = sel_q;
    out0_d  = out0_q;
    out1_d  = out1_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
`ifdef DEMUX_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        // Ack is deliberately not looked at here, even alongside Load.
        if (Load) begin
          sel_d   = Sel;
          state_d = ST_WAIT;
`ifdef DEMUX_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      ST_WAIT: begin
        // Ack is tested before the counter, so Ack on the last permitted
        // edge still captures.
        if (Ack) begin
          if (sel_q) begin
            out1_d  = In;
            done1_d = 1'b1;
          end else begin
            out0_d  = In;
            done0_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
`ifdef DEMUX_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers (synchronous reset)
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (Reset) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      out0_q  <= '0;
      out1_q  <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
`ifdef DEMUX_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
`ifdef DEMUX_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign Out0  = out0_q;
  assign Out1  = out1_q;
  assign Busy  = (state_q == ST_WAIT);
  assign Done0 = done0_q;
  assign Done1 = done1_q;
`ifdef DEMUX_TIMEOUT_EN
  assign Timeout = timeout_q;
`else
  assign Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_demux2_reg32.sv
// ---------------------------------------------------------------------------
// tb_demux2_reg32 -- self-checking bench for demux2_reg32
//
// Inputs change just after the falling edge. A transaction-level model
// (pending request, WAIT-edge age, expected registers and pulses) is updated
// on each rising edge. A compare process checks every DUT output against it
// 2 time units after each rising edge. The directed sequence also pins
// hand-computed literals at key points. Honours DEMUX_TIMEOUT_EN the same
// way the design does.
// ---------------------------------------------------------------------------
module tb_demux2_reg32;

  localparam int unsigned W  = 32;
  localparam int unsigned TO = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         sel, load, ack;
  logic [W-1:0] out0, out1;
  logic         busy, done0, done1, timeout;

  int total = 0;
  int bad   = 0;

  demux2_reg32 #(
    .WIDTH          (W),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (4)
  ) dut (
    .Clk     (clk),
    .Reset   (reset),
    .In      (din),
    .Sel     (sel),
    .Load    (load),
    .Ack     (ack),
    .Out0    (out0),
    .Out1    (out1),
    .Busy    (busy),
    .Done0   (done0),
    .Done1   (done1),
    .Timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Transaction model: a request is either pending or not; while pending we
  // count how many WAIT edges it has seen. Capture on Ack, give up when the
  // TO-th WAIT edge passes without Ack.
  // -------------------------------------------------------------------------
  logic         m_pending = 1'b0;
  logic         m_dest    = 1'b0;
  int           m_age     = 0;
  logic [W-1:0] m_out0    = '0;
  logic [W-1:0] m_out1    = '0;
  logic         m_d0 = 1'b0, m_d1 = 1'b0, m_to = 1'b0;

  always @(posedge clk) begin
    m_d0 = 1'b0;
    m_d1 = 1'b0;
    m_to = 1'b0;
    if (reset) begin
      m_pending = 1'b0;
      m_dest    = 1'b0;
      m_age     = 0;
      m_out0    = '0;
      m_out1    = '0;
    end else if (!m_pending) begin
      if (load) begin
        m_pending = 1'b1;
        m_dest    = sel;
        m_age     = 0;
      end
    end else begin
      m_age = m_age + 1;
      if (ack) begin
        if (m_dest) begin
          m_out1 = din;
          m_d1   = 1'b1;
        end else begin
          m_out0 = din;
          m_d0   = 1'b1;
        end
        m_pending = 1'b0;
      end
`ifdef DEMUX_TIMEOUT_EN
      else if (m_age == TO) begin
        m_to      = 1'b1;
        m_pending = 1'b0;
      end
`endif
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      check("out0",    out0,             m_out0);
      check("out1",    out1,             m_out1);
      check("busy",    {31'b0, busy},    {31'b0, m_pending});
      check("done0",   {31'b0, done0},   {31'b0, m_d0});
      check("done1",   {31'b0, done1},   {31'b0, m_d1});
      check("timeout", {31'b0, timeout}, {31'b0, m_to});
    end
  end

  // Hard time limit so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // -------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // -------------------------------------------------------------------------
  initial begin
    reset = 1'b1; load = 1'b0; sel = 1'b0; ack = 1'b0; din = '0;
    cyc(2);
    check("rst_out0",    out0, 32'h0);
    check("rst_out1",    out1, 32'h0);
    check("rst_flags",   {28'b0, busy, done0, done1, timeout}, 32'h0);
    reset = 1'b0;
    cyc(5);
    check("idle_out0",   out0, 32'h0);
    check("idle_out1",   out1, 32'h0);
    check("idle_flags",  {28'b0, busy, done0, done1, timeout}, 32'h0);

    // Capture into Out1, minimum latency.
    load = 1'b1; sel = 1'b1;
    cyc(1);
    check("c1_busy",     {31'b0, busy}, 32'h1);
    load = 1'b0; ack = 1'b1; din = 32'hAAAAAAAA;
    cyc(1);
    check("c1_out1",     out1, 32'hAAAAAAAA);
    check("c1_out0",     out0, 32'h0);
    check("c1_flags",    {28'b0, busy, done0, done1, timeout}, 32'h2);
    ack = 1'b0; din = '0;
    cyc(1);
    check("c1_done_end", {31'b0, done1}, 32'h0);

    // Capture into Out0, Sel toggled during WAIT, late Ack.
    load = 1'b1; sel = 1'b0;
    cyc(1);
    load = 1'b0; sel = 1'b1;
    cyc(4);
    ack = 1'b1; din = 32'hFFFFFFFF;
    cyc(1);
    check("c0_out0",     out0, 32'hFFFFFFFF);
    check("c0_out1",     out1, 32'hAAAAAAAA);
    check("c0_flags",    {28'b0, busy, done0, done1, timeout}, 32'h4);
    ack = 1'b0;

    // No Ack for TO edges after the request edge.
    load = 1'b1; sel = 1'b1; din = 32'h5A5A5A5A;
    cyc(1);
    load = 1'b0;
    cyc(TO - 1);
    check("to_pre",      {28'b0, busy, done0, done1, timeout}, 32'h8);
    cyc(1);
`ifdef DEMUX_TIMEOUT_EN
    check("to_flags",    {28'b0, busy, done0, done1, timeout}, 32'h1);
    check("to_out0",     out0, 32'hFFFFFFFF);
    check("to_out1",     out1, 32'hAAAAAAAA);
    load = 1'b1; sel = 1'b1;
    cyc(1);
    load = 1'b0; ack = 1'b1;
    cyc(1);
`else
    check("nto_flags",   {28'b0, busy, done0, done1, timeout}, 32'h8);
    check("nto_out1",    out1, 32'hAAAAAAAA);
    ack = 1'b1;
    cyc(1);
`endif
    check("after_to_out1",  out1, 32'h5A5A5A5A);
    check("after_to_flags", {28'b0, busy, done0, done1, timeout}, 32'h2);
    ack = 1'b0;

    // Ack on the final permitted WAIT edge wins over timeout.
    load = 1'b1; sel = 1'b0;
    cyc(1);
    load = 1'b0;
    cyc(TO - 1);
    ack = 1'b1; din = 32'h13579BDF;
    cyc(1);
    check("race_out0",   out0, 32'h13579BDF);
    check("race_flags",  {28'b0, busy, done0, done1, timeout}, 32'h4);
    ack = 1'b0;
    cyc(1);

    // Load during WAIT is ignored and not queued.
    load = 1'b1; sel = 1'b1;
    cyc(1);
    load = 1'b0; sel = 1'b0;
    cyc(1);
    load = 1'b1;
    cyc(1);
    load = 1'b0; ack = 1'b1; din = 32'h2468ACE0;
    cyc(1);
    check("ign_out1",    out1, 32'h2468ACE0);
    check("ign_flags",   {28'b0, busy, done0, done1, timeout}, 32'h2);
    ack = 1'b0;
    cyc(1);
    check("ign_idle",    {31'b0, busy}, 32'h0);

    // Ack in IDLE changes nothing.
    ack = 1'b1; din = 32'h12345678;
    cyc(2);
    check("ackidle_out0",  out0, 32'h13579BDF);
    check("ackidle_out1",  out1, 32'h2468ACE0);
    check("ackidle_flags", {28'b0, busy, done0, done1, timeout}, 32'h0);

    // Load and Ack together: Ack ignored on the request edge.
    load = 1'b1; sel = 1'b0; din = 32'hDEADBEEF;
    cyc(1);
    check("la_flags",    {28'b0, busy, done0, done1, timeout}, 32'h8);
    check("la_out0",     out0, 32'h13579BDF);
    load = 1'b0;
    cyc(1);
    check("la_cap_out0", out0, 32'hDEADBEEF);
    check("la_cap_flags",{28'b0, busy, done0, done1, timeout}, 32'h4);
    ack = 1'b0;

    // Reset mid-WAIT: capture lost, no pulse.
    load = 1'b1; sel = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(3);
    reset = 1'b1; ack = 1'b1; din = 32'hFFFFFFFF;
    cyc(1);
    check("mr_out0",     out0, 32'h0);
    check("mr_out1",     out1, 32'h0);
    check("mr_flags",    {28'b0, busy, done0, done1, timeout}, 32'h0);
    reset = 1'b0; ack = 1'b0;
    cyc(2);
    check("mr_after",    {28'b0, busy, done0, done1, timeout}, 32'h0);
    check("mr_out1_hold", out1, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
